wb_port_arbiter: RTL and testbench

Writeback controller for the single write port of `register_file` in the rv32i_sc core. It arbitrates between the ALU and load/store unit writeback requesters with round-robin fairness and drives the register file write port from registers. It also keeps a 32-entry pending-write scoreboard so decode can detect read-after-write hazards on rs1/rs2.

---
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter for the rv32i_sc register file. It round-robins between the ALU and LSU
// writeback requesters, registers the winning write, and keeps a pending-write scoreboard for decode.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module wb_port_arbiter #(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0]     alu_wb_data,
  output logic                      alu_wb_ready,
  input  logic                      lsu_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_wb_addr,
  input  logic [DATA_WIDTH-1:0]     lsu_wb_data,
  output logic                      lsu_wb_ready,
  input  logic                      mark_enable,
  input  logic [REG_ADDR_WIDTH-1:0] mark_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      write_enable,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]     write_data
);

  localparam int DEPTH = 1 << REG_ADDR_WIDTH;

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

  prio_e                     prio;
  prio_e                     prio_next;
  logic                      grant_alu;
  logic                      grant_lsu;
  logic                      win;
  logic [REG_ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]     win_data;
  logic [DEPTH-1:0]          pend;
  logic [DEPTH-1:0]          pend_next;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant_alu = alu_wb_valid && (!lsu_wb_valid || (prio == PRIO_ALU));
    grant_lsu = lsu_wb_valid && (!alu_wb_valid || (prio == PRIO_LSU));
    win       = grant_alu || grant_lsu;
    win_addr  = alu_wb_addr;
    win_data  = alu_wb_data;
    prio_next = prio;
    if (grant_lsu) begin
      win_addr = lsu_wb_addr;
      win_data = lsu_wb_data;
    end
    // The loser of this cycle (or the idle side) is favoured next time.
    if (grant_alu) begin
      prio_next = PRIO_LSU;
    end else if (grant_lsu) begin
      prio_next = PRIO_ALU;
    end
  end

  assign alu_wb_ready = grant_alu && !rst;
  assign lsu_wb_ready = grant_lsu && !rst;

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio         <= PRIO_ALU;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      prio         <= prio_next;
      write_enable <= win && (win_addr != '0);
      if (win) begin
        write_addr <= win_addr;
        write_data <= win_data;
      end
    end
  end

  // Clear on retirement first, then set on issue, so a re-mark in the retiring cycle survives.
  always_comb begin
    pend_next = pend;
    if (write_enable) begin
      pend_next[write_addr] = 1'b0;
    end
    if (mark_enable && (mark_addr != '0)) begin
      pend_next[mark_addr] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // NOTE: the scoreboard is reset on purpose; pending bits are meaningless after a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  // The register file forwards same-cycle write data, so the retiring register is not a hazard.
  assign rs1_busy = pend[rs1_addr] && !(write_enable && (write_addr == rs1_addr));
  assign rs2_busy = pend[rs2_addr] && !(write_enable && (write_addr == rs2_addr));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model of the write port.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_valid, lsu_wb_valid, mark_enable;
  logic [4:0]  alu_wb_addr, lsu_wb_addr, mark_addr, rs1_addr, rs2_addr;
  logic [31:0] alu_wb_data, lsu_wb_data;
  logic        alu_wb_ready, lsu_wb_ready, rs1_busy, rs2_busy, write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_addr  (lsu_wb_addr),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .mark_enable  (mark_enable),
    .mark_addr    (mark_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: set of registers awaiting writeback, the one write in flight,
  // and which requester won most recently (the other one is favoured on contention).
  bit        m_pend[32];
  bit        m_lsu_won_last;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        exp_alu, exp_lsu, exp_b1, exp_b2;
  bit        alu_took, lsu_took;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_alu_ready", alu_wb_ready, 0);
      check("rst_lsu_ready", lsu_wb_ready, 0);
      check("rst_write_enable", write_enable, 0);
      check("rst_write_addr", write_addr, 0);
      check("rst_write_data", write_data, 0);
      check("rst_rs1_busy", rs1_busy, 0);
      check("rst_rs2_busy", rs2_busy, 0);
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_lsu_won_last = 1'b1;
      m_we           = 1'b0;
      m_waddr        = '0;
      m_wdata        = '0;
      alu_took       = 1'b0;
      lsu_took       = 1'b0;
    end else begin
      if (alu_wb_valid && lsu_wb_valid) begin
        exp_alu = m_lsu_won_last;
        exp_lsu = !m_lsu_won_last;
      end else begin
        exp_alu = alu_wb_valid;
        exp_lsu = lsu_wb_valid;
      end
      exp_b1 = m_pend[rs1_addr] && !(m_we && m_waddr == rs1_addr);
      exp_b2 = m_pend[rs2_addr] && !(m_we && m_waddr == rs2_addr);
      check("alu_wb_ready", alu_wb_ready, exp_alu);
      check("lsu_wb_ready", lsu_wb_ready, exp_lsu);
      check("write_enable", write_enable, m_we);
      check("write_addr", write_addr, m_waddr);
      check("write_data", write_data, m_wdata);
      check("rs1_busy", rs1_busy, exp_b1);
      check("rs2_busy", rs2_busy, exp_b2);
      alu_took = alu_wb_valid && alu_wb_ready;
      lsu_took = lsu_wb_valid && lsu_wb_ready;
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (mark_enable && mark_addr != 0) m_pend[mark_addr] = 1'b1;
      if (exp_alu) begin
        m_we = (alu_wb_addr != 0); m_waddr = alu_wb_addr; m_wdata = alu_wb_data;
        m_lsu_won_last = 1'b0;
      end else if (exp_lsu) begin
        m_we = (lsu_wb_addr != 0); m_waddr = lsu_wb_addr; m_wdata = lsu_wb_data;
        m_lsu_won_last = 1'b1;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
    mark_enable = 0; mark_addr = 0; rs1_addr = 3; rs2_addr = 4;
    step(); step();
    rst = 1'b0;

    // Idle, then mark x3: visible from the following cycle only.
    @(negedge clk);
    check("idle_write_enable", write_enable, 0);
    check("idle_rs1_busy", rs1_busy, 0);
    step(); mark_enable = 1; mark_addr = 3;
    @(negedge clk); check("mark3_same_cycle", rs1_busy, 0);
    step(); mark_enable = 0;
    @(negedge clk);
    check("mark3_rs1_busy", rs1_busy, 1);
    check("mark3_rs2_busy", rs2_busy, 0);

    // ALU-only write to x1, marked in the same cycle.
    step(); alu_wb_valid = 1; alu_wb_addr = 1; alu_wb_data = 32'h1234_5678;
    mark_enable = 1; mark_addr = 1; rs1_addr = 1;
    @(negedge clk); check("x1_alu_ready", alu_wb_ready, 1);
    step(); alu_wb_valid = 0; mark_enable = 0;
    @(negedge clk);
    check("x1_write_enable", write_enable, 1);
    check("x1_write_addr", write_addr, 1);
    check("x1_write_data", write_data, 32'h1234_5678);
    check("x1_masked_busy", rs1_busy, 0);
    step();
    @(negedge clk); check("x1_cleared_busy", rs1_busy, 0);

    // LSU write to x0: accepted but not written; x0 never busy.
    step(); lsu_wb_valid = 1; lsu_wb_addr = 0; lsu_wb_data = 32'hDEAD_BEEF;
    mark_enable = 1; mark_addr = 0; rs1_addr = 0;
    @(negedge clk);
    check("x0_lsu_ready", lsu_wb_ready, 1);
    check("x0_rs1_busy_a", rs1_busy, 0);
    step(); lsu_wb_valid = 0; mark_enable = 0;
    @(negedge clk);
    check("x0_write_enable", write_enable, 0);
    check("x0_rs1_busy_b", rs1_busy, 0);

    // Contention: grants ALU, LSU, ALU, LSU; writes x3, x4, x5, x6.
    step();
    alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = 32'h5555_AAAA;
    lsu_wb_valid = 1; lsu_wb_addr = 4; lsu_wb_data = 32'hFFFF_0000;
    @(negedge clk);
    check("c0_alu_ready", alu_wb_ready, 1);
    check("c0_lsu_ready", lsu_wb_ready, 0);
    step(); alu_wb_addr = 5; alu_wb_data = 32'h1111_1111;
    @(negedge clk);
    check("c1_lsu_ready", lsu_wb_ready, 1);
    check("c1_alu_ready", alu_wb_ready, 0);
    check("c1_write_addr", write_addr, 3);
    check("c1_write_data", write_data, 32'h5555_AAAA);
    step(); lsu_wb_addr = 6; lsu_wb_data = 32'h2222_2222;
    @(negedge clk);
    check("c2_alu_ready", alu_wb_ready, 1);
    check("c2_write_addr", write_addr, 4);
    check("c2_write_data", write_data, 32'hFFFF_0000);
    step(); alu_wb_valid = 0;
    @(negedge clk);
    check("c3_lsu_ready", lsu_wb_ready, 1);
    check("c3_write_addr", write_addr, 5);
    check("c3_write_data", write_data, 32'h1111_1111);
    step(); lsu_wb_valid = 0;
    @(negedge clk);
    check("c4_write_addr", write_addr, 6);
    check("c4_write_data", write_data, 32'h2222_2222);

    // Mark x2, retire it, re-mark it in the retiring cycle.
    step(); mark_enable = 1; mark_addr = 2; rs1_addr = 2;
    step(); mark_enable = 0;
    alu_wb_valid = 1; alu_wb_addr = 2; alu_wb_data = 32'hAABB_CCDD;
    @(negedge clk); check("x2_busy_before", rs1_busy, 1);
    step(); alu_wb_valid = 0; mark_enable = 1; mark_addr = 2;
    @(negedge clk);
    check("x2_write_data", write_data, 32'hAABB_CCDD);
    check("x2_busy_masked", rs1_busy, 0);
    step(); mark_enable = 0;
    @(negedge clk); check("x2_remark_busy", rs1_busy, 1);

    // Build pend = {2,3,4} with a write in flight, then reset asynchronously mid-cycle.
    step(); mark_enable = 1; mark_addr = 3;
    step(); mark_addr = 4; alu_wb_valid = 1; alu_wb_addr = 7; alu_wb_data = 32'h0000_0077;
    step(); mark_enable = 0; rs1_addr = 3; rs2_addr = 4;
    alu_wb_addr = 8; lsu_wb_valid = 1; lsu_wb_addr = 9;
    #1;
    check("pre_rst_write_enable", write_enable, 1);
    check("pre_rst_rs1_busy", rs1_busy, 1);
    check("pre_rst_rs2_busy", rs2_busy, 1);
    rst = 1'b1;
    #1;
    check("async_write_enable", write_enable, 0);
    check("async_alu_ready", alu_wb_ready, 0);
    check("async_lsu_ready", lsu_wb_ready, 0);
    check("async_rs1_busy", rs1_busy, 0);
    check("async_rs2_busy", rs2_busy, 0);
    step(); rst = 1'b0; alu_wb_valid = 0; lsu_wb_valid = 0;
    @(negedge clk); check("post_rst_rs1_busy", rs1_busy, 0);

    // Randomized traffic; requesters hold their request until accepted.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!alu_wb_valid || alu_took) begin
        alu_wb_valid = ($urandom_range(0, 3) != 0);
        alu_wb_addr  = 5'($urandom_range(0, 7));
        alu_wb_data  = $urandom;
      end
      if (!lsu_wb_valid || lsu_took) begin
        lsu_wb_valid = ($urandom_range(0, 2) != 0);
        lsu_wb_addr  = 5'($urandom_range(0, 7));
        lsu_wb_data  = $urandom;
      end
      mark_enable = ($urandom_range(0, 1) != 0);
      mark_addr   = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
